// File: rtl/alu_seq_seg_if.sv
// Operand/op request, result flags and display bus between the front panel and alu_seq_seg.
// Master drives the request; slave (the ALU) drives result, status and display lines.
interface alu_seq_seg_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned NDIG  = (RES_W + 3) / 4;

  logic             start;
  logic [2:0]       sel;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [RES_W-1:0] result;
  logic             neg;
  logic             ovf;
  logic [0:6]       seg;
  logic [NDIG-1:0]  dig_en;

  modport master (
    output start, sel, in1, in2,
    input  busy, done, result, neg, ovf, seg, dig_en
  );

  modport slave (
    input  start, sel, in1, in2,
    output busy, done, result, neg, ovf, seg, dig_en
  );
endinterface

// File: rtl/alu_seq_seg.sv
// Sequential ALU with accumulator, iterative shift-add multiplier and a
// multiplexed hex 7-segment scanner that shows the held result.
module alu_seq_seg #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  alu_seq_seg_if.slave bus
);
  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned NDIG  = (RES_W + 3) / 4;
  localparam int unsigned PAD_W = NDIG * 4;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_ACC = 3'd6;

  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_neg;
  logic             r_ovf;
  logic [RES_W-1:0] r_result;
  logic [RES_W-1:0] r_acc;
  logic [RES_W-1:0] r_prod;
  logic [RES_W-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [SC_W-1:0]  r_scan;
  logic [IDX_W-1:0] r_idx;
  logic [NDIG-1:0]  r_dig_en;
  logic [0:6]       r_seg;

  logic [RES_W:0]   w_acc_sum;
  logic [RES_W-1:0] w_prod_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [PAD_W-1:0] w_res_pad;
  logic [3:0]       w_nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b1111110;
      4'h1: hex7 = 7'b0110000;
      4'h2: hex7 = 7'b1101101;
      4'h3: hex7 = 7'b1111001;
      4'h4: hex7 = 7'b0110011;
      4'h5: hex7 = 7'b1011011;
      4'h6: hex7 = 7'b1011111;
      4'h7: hex7 = 7'b1110000;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1111011;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b0011111;
      4'hC: hex7 = 7'b1001110;
      4'hD: hex7 = 7'b0111101;
      4'hE: hex7 = 7'b1001111;
      default: hex7 = 7'b1000111;
    endcase
  endfunction

  always_comb begin
    w_acc_sum  = {1'b0, r_acc} + (RES_W + 1)'(bus.in1);
    w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
  end

  // Op capture, single-cycle ops and the shift-add multiply sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_done <= (bus.sel != OP_MUL);
            case (bus.sel)
              OP_ADD: begin
                r_result <= RES_W'(bus.in1) + RES_W'(bus.in2);
                r_neg    <= 1'b0;
              end
              OP_SUB: begin
                r_result <= RES_W'(bus.in1) - RES_W'(bus.in2);
                r_neg    <= (bus.in1 < bus.in2);
              end
              OP_AND: begin
                r_result <= RES_W'(bus.in1 & bus.in2);
                r_neg    <= 1'b0;
              end
              OP_OR: begin
                r_result <= RES_W'(bus.in1 | bus.in2);
                r_neg    <= 1'b0;
              end
              OP_XOR: begin
                r_result <= RES_W'(bus.in1 ^ bus.in2);
                r_neg    <= 1'b0;
              end
              OP_MUL: begin
                r_state  <= S_MUL;
                r_busy   <= 1'b1;
                r_cnt    <= '0;
                r_prod   <= '0;
                r_mcand  <= RES_W'(bus.in1);
                r_mplier <= bus.in2;
              end
              OP_ACC: begin
                r_acc    <= w_acc_sum[RES_W-1:0];
                r_result <= w_acc_sum[RES_W-1:0];
                r_ovf    <= w_acc_sum[RES_W];
                r_neg    <= 1'b0;
              end
              default: begin
                r_acc    <= '0;
                r_result <= '0;
                r_neg    <= 1'b0;
                r_ovf    <= 1'b0;
              end
            endcase
          end
        end
        S_MUL: begin
          r_prod   <= w_prod_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          // Last partial product folds straight into the result.
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_neg    <= 1'b0;
            r_result <= w_prod_nxt;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_idx_nxt = r_idx;
    if (r_scan == SC_W'(SCAN_DIV - 1)) begin
      w_idx_nxt = (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + IDX_W'(1);
    end
    w_res_pad = PAD_W'(r_result);
    w_nib     = 4'(w_res_pad >> {w_idx_nxt, 2'b00});
  end

  // Digit scanner: dig_en and seg change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan   <= '0;
      r_idx    <= '0;
      r_dig_en <= NDIG'(1);
      r_seg    <= 7'b1111110;
    end else begin
      r_scan   <= (r_scan == SC_W'(SCAN_DIV - 1)) ? '0 : r_scan + SC_W'(1);
      r_idx    <= w_idx_nxt;
      r_dig_en <= NDIG'(1) << w_idx_nxt;
      r_seg    <= hex7(w_nib);
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.neg    = r_neg;
  assign bus.ovf    = r_ovf;
  assign bus.seg    = r_seg;
  assign bus.dig_en = r_dig_en;

endmodule

// File: tb/tb_alu_seq_seg.sv
// Bench for alu_seq_seg: cycle-level behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_seq_seg;
  localparam int unsigned WIDTH    = 4;
  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned RES_W    = 2 * WIDTH;
  localparam int unsigned NDIG     = (RES_W + 3) / 4;
  localparam longint      MODV     = longint'(1) << RES_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_seq_seg_if #(.WIDTH(WIDTH)) bus ();

  alu_seq_seg #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hex7(input longint n);
    logic [6:0] t [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                           7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                           7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                           7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return t[int'(n & 15)];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state after each clock edge.
  longint m_result = 0, m_acc = 0, m_pending = 0, m_seg_src = 0;
  int     m_busy_left = 0, m_n = 0;
  bit     m_done = 0, m_neg = 0, m_ovf = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_result <= 0; m_acc <= 0; m_pending <= 0; m_seg_src <= 0;
      m_busy_left <= 0; m_n <= 0; m_done <= 0; m_neg <= 0; m_ovf <= 0;
    end else begin
      m_seg_src <= m_result;
      m_n       <= m_n + 1;
      m_done    <= 0;
      if (m_busy_left > 0) begin
        m_busy_left <= m_busy_left - 1;
        if (m_busy_left == 1) begin
          m_result <= m_pending; m_done <= 1; m_neg <= 0;
        end
      end else if (bus.start) begin
        case (bus.sel)
          3'd0: begin m_result <= longint'(bus.in1) + bus.in2; m_neg <= 0; m_done <= 1; end
          3'd1: begin
            m_result <= (longint'(bus.in1) - bus.in2 + MODV) % MODV;
            m_neg <= (bus.in1 < bus.in2); m_done <= 1;
          end
          3'd2: begin m_result <= longint'(bus.in1 & bus.in2); m_neg <= 0; m_done <= 1; end
          3'd3: begin m_result <= longint'(bus.in1 | bus.in2); m_neg <= 0; m_done <= 1; end
          3'd4: begin m_result <= longint'(bus.in1 ^ bus.in2); m_neg <= 0; m_done <= 1; end
          3'd5: begin m_pending <= longint'(bus.in1) * bus.in2; m_busy_left <= WIDTH; end
          3'd6: begin
            m_acc    <= (m_acc + bus.in1) % MODV;
            m_result <= (m_acc + bus.in1) % MODV;
            m_ovf    <= (m_acc + bus.in1) >= MODV;
            m_neg    <= 0; m_done <= 1;
          end
          default: begin m_acc <= 0; m_result <= 0; m_neg <= 0; m_ovf <= 0; m_done <= 1; end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int idx;
    idx = (m_n / SCAN_DIV) % NDIG;
    check("result", 64'(bus.result), 64'(m_result));
    check("busy",   64'(bus.busy),   64'(m_busy_left > 0));
    check("done",   64'(bus.done),   64'(m_done));
    check("neg",    64'(bus.neg),    64'(m_neg));
    check("ovf",    64'(bus.ovf),    64'(m_ovf));
    check("dig_en", 64'(bus.dig_en), 64'(1) << idx);
    check("seg",    64'(bus.seg),    64'(hex7(m_seg_src >> (4 * idx))));
  end

  task automatic op(input logic [2:0] s, input int a, input int b);
    @(negedge clk);
    bus.start = 1'b1; bus.sel = s; bus.in1 = WIDTH'(a); bus.in2 = WIDTH'(b);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bit ok;
    bus.start = 1'b0; bus.sel = '0; bus.in1 = '0; bus.in2 = '0;
    repeat (2) @(negedge clk);
    check("rst_result", 64'(bus.result), 64'h0);
    check("rst_dig_en", 64'(bus.dig_en), 64'h1);
    check("rst_seg",    64'(bus.seg),    64'b1111110);
    #2 rst = 1'b0;

    op(3'd0, 5, 2);
    check("add_result", 64'(bus.result), 64'h07);
    check("add_done",   64'(bus.done),   64'h1);
    @(negedge clk);
    check("add_done_off", 64'(bus.done), 64'h0);

    op(3'd1, 2, 5);
    check("sub_result", 64'(bus.result), 64'hFD);
    check("sub_neg",    64'(bus.neg),    64'h1);
    op(3'd2, 7, 6);
    check("and_result", 64'(bus.result), 64'h06);
    check("and_neg",    64'(bus.neg),    64'h0);

    // MUL with a start pulse during busy that must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.sel = 3'd5; bus.in1 = 4'd7; bus.in2 = 4'd6;
    @(negedge clk);
    check("mul_busy", 64'(bus.busy), 64'h1);
    check("mul_hold", 64'(bus.result), 64'h06);
    bus.sel = 3'd0; bus.in1 = 4'd1; bus.in2 = 4'd1;
    nb = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) nb++;
      else break;
    end
    check("mul_busy_cycles", 64'(nb), 64'd4);
    check("mul_result", 64'(bus.result), 64'h2A);
    check("mul_done",   64'(bus.done),   64'h1);
    @(negedge clk);
    check("mul_no_extra_done", 64'(bus.done), 64'h0);
    check("mul_result_kept", 64'(bus.result), 64'h2A);

    // Display scan of 0x2A.
    repeat (2) @(negedge clk);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = (bus.dig_en == 2'b10); end
    check("scan_wait_d1", 64'(ok), 64'h1);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = (bus.dig_en == 2'b01); end
    check("scan_wait_d0", 64'(ok), 64'h1);
    for (int j = 0; j < 4; j++) begin
      check("scan_d0_en",  64'(bus.dig_en), 64'b01);
      check("scan_d0_seg", 64'(bus.seg),    64'b1110111);
      @(negedge clk);
    end
    for (int j = 0; j < 4; j++) begin
      check("scan_d1_en",  64'(bus.dig_en), 64'b10);
      check("scan_d1_seg", 64'(bus.seg),    64'b1101101);
      @(negedge clk);
    end
    check("scan_wrap", 64'(bus.dig_en), 64'b01);

    // Accumulator wrap.
    op(3'd7, 0, 0);
    for (int i = 0; i < 17; i++) op(3'd6, 15, 0);
    check("acc17_result", 64'(bus.result), 64'hFF);
    check("acc17_ovf",    64'(bus.ovf),    64'h0);
    op(3'd6, 15, 0);
    check("acc18_result", 64'(bus.result), 64'h0E);
    check("acc18_ovf",    64'(bus.ovf),    64'h1);
    op(3'd7, 0, 0);
    check("clr_result", 64'(bus.result), 64'h0);
    check("clr_ovf",    64'(bus.ovf),    64'h0);

    // Reset in the middle of a multiply.
    op(3'd5, 7, 6);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("rstmul_busy",   64'(bus.busy),   64'h0);
    check("rstmul_result", 64'(bus.result), 64'h0);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rstmul_no_done", 64'(bus.done), 64'h0);
    end
    op(3'd0, 1, 2);
    check("post_rst_add", 64'(bus.result), 64'h03);

    // Randomized traffic, including starts while busy.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.sel   = 3'($urandom_range(0, 7));
      bus.in1   = WIDTH'($urandom);
      bus.in2   = WIDTH'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
